// File: rtl/mul_seq_server_if.sv
// Start/busy multiply handshake between an iterative arithmetic client (master)
// and the shift-add multiplier that serves it (slave).
interface mul_seq_server_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0]   a_bi;
    logic [WIDTH-1:0]   b_bi;
    logic               start_i;
    logic               busy_o;
    logic [2*WIDTH-1:0] y_bo;

    modport master (
        output a_bi,
        output b_bi,
        output start_i,
        input  busy_o,
        input  y_bo
    );

    modport slave (
        input  a_bi,
        input  b_bi,
        input  start_i,
        output busy_o,
        output y_bo
    );
endinterface

// File: rtl/mul_seq_server.sv
// Sequential shift-add multiplier: one multiplier bit per clock, fixed WIDTH-cycle
// busy window, product registered and published only on the completing edge.
module mul_seq_server #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mul_seq_server_if.slave   bus
);
    localparam int unsigned   PW      = 2 * WIDTH;
    localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StWork} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     y_q, y_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]     acc_sum;
    logic              last_iter;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        last_iter = (cnt_q == CntLast);
        state_d   = state_q;
        unique case (state_q)
            StIdle:  if (bus.start_i) state_d = StWork;
            StWork:  if (last_iter)   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy_o = (state_q == StWork);
        bus.y_bo   = y_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
        end
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    mcand_d  = PW'(bus.a_bi);
                    mplier_d = bus.b_bi;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            StWork: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Publish including this iteration's add; y never shows partial sums.
                if (last_iter) y_d = acc_sum;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mul_seq_server.sv
// Randomised self-checking bench: a cycle-level behavioural model (countdown + a*b)
// is compared against busy_o/y_bo on every falling edge, plus literal directed checks.
module tb_mul_seq_server;
    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    mul_seq_server_if #(.WIDTH(W)) bus ();

    mul_seq_server #(.WIDTH(W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int           m_left = 0;
    logic [PW-1:0] m_pend = '0;
    logic [PW-1:0] m_y    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: idle accepts start, then WIDTH busy cycles, product appears as busy drops.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_left = 0;
            m_y    = '0;
        end else if (m_left == 0) begin
            if (bus.start_i) begin
                m_left = W;
                m_pend = PW'(bus.a_bi) * PW'(bus.b_bi);
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_y = m_pend;
        end
    end

    always @(negedge clk_i) begin
        chk("busy_vs_model", 32'(bus.busy_o), 32'(m_left != 0));
        chk("y_vs_model", 32'(bus.y_bo), 32'(m_y));
    end

    // Count busy-high falling edges until busy drops, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy_o && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        if (bus.busy_o) chk("busy_timeout", 32'(bus.busy_o), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [31:0] exp_y, input string name);
        int n;
        @(negedge clk_i);
        bus.a_bi    = a;
        bus.b_bi    = b;
        bus.start_i = 1'b1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        bus.a_bi    = 8'($urandom);
        bus.b_bi    = 8'($urandom);
        count_busy(n);
        chk({name, "_busy_len"}, 32'(n), 32'd8);
        chk({name, "_y"}, 32'(bus.y_bo), exp_y);
    endtask

    initial begin
        int n;
        bus.a_bi    = '0;
        bus.b_bi    = '0;
        bus.start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("idle_busy", 32'(bus.busy_o), 32'd0);
        chk("idle_y", 32'(bus.y_bo), 32'd0);

        run_op(8'd13, 8'd11, 32'd143, "13x11");
        run_op(8'd255, 8'd255, 32'd65025, "255x255");
        run_op(8'd0, 8'd200, 32'd0, "0x200");

        // Start during busy must be ignored.
        @(negedge clk_i);
        bus.a_bi = 8'd6; bus.b_bi = 8'd6; bus.start_i = 1'b1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        bus.a_bi = 8'd2; bus.b_bi = 8'd2; bus.start_i = 1'b1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        count_busy(n);
        chk("ignore_busy_len", 32'(n), 32'd5);
        chk("ignore_y", 32'(bus.y_bo), 32'd36);
        repeat (3) @(negedge clk_i);
        chk("ignore_stays_idle", 32'(bus.busy_o), 32'd0);

        // Asynchronous abort mid-operation.
        @(negedge clk_i);
        bus.a_bi = 8'd7; bus.b_bi = 8'd7; bus.start_i = 1'b1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("pre_abort_busy", 32'(bus.busy_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_y", 32'(bus.y_bo), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        run_op(8'd4, 8'd4, 32'd16, "4x4");

        // Continuous start: 8 high / 1 low, result 15 in each low cycle.
        @(negedge clk_i);
        bus.a_bi = 8'd5; bus.b_bi = 8'd3; bus.start_i = 1'b1;
        @(negedge clk_i);
        for (int r = 0; r < 3; r++) begin
            count_busy(n);
            chk("held_busy_len", 32'(n), 32'd8);
            chk("held_y", 32'(bus.y_bo), 32'd15);
            @(negedge clk_i);
            chk("held_low_len", 32'(bus.busy_o), 32'd1);
        end
        bus.start_i = 1'b0;
        count_busy(n);

        // Random traffic with start toggling freely; per-cycle model compare covers it.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            bus.a_bi    = 8'($urandom);
            bus.b_bi    = 8'($urandom);
            bus.start_i = ($urandom_range(0, 3) == 0);
        end
        bus.start_i = 1'b0;
        @(negedge clk_i);
        count_busy(n);
        repeat (2) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
